// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller for the E stage: fixed-latency busy counter, HI/LO ownership, D-stage stall.
// Optional build macro MD_DIVZERO_HOLD_EN: divide by zero leaves HI/LO untouched instead of writing lo=all-ones, hi=dividend.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, BUSY} state_t;

`ifdef MD_DIVZERO_HOLD_EN
    localparam bit DIVZERO_HOLD = 1'b1;
`else
    localparam bit DIVZERO_HOLD = 1'b0;
`endif

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  counter;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_div;
    logic        op_signed;
    logic        start;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quot;
    logic [31:0] rem;

    assign start = md_en && (md_op >= 3'd1) && (md_op <= 3'd4);
    assign busy  = (state == BUSY);
    assign stall = d_is_md && (busy || start);

    // Divide on magnitudes so the signed overflow case falls out naturally (0x80000000 / 1, negated).
    always_comb begin
        ext_a   = op_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        ext_b   = op_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        product = ext_a * ext_b;
        neg_a   = op_signed && op_a[31];
        neg_b   = op_signed && op_b[31];
        mag_a   = neg_a ? (32'd0 - op_a) : op_a;
        mag_b   = neg_b ? (32'd0 - op_b) : op_b;
        mag_q   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        mag_r   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        quot    = (neg_a ^ neg_b) ? (32'd0 - mag_q) : mag_q;
        rem     = neg_a ? (32'd0 - mag_r) : mag_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= 4'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a      <= rs_data;
                        op_b      <= rt_data;
                        op_div    <= (md_op >= 3'd3);
                        op_signed <= (md_op == 3'd1) || (md_op == 3'd3);
                        counter   <= (md_op >= 3'd3) ? DIV_LOAD : MULT_LOAD;
                        state     <= BUSY;
                    end else if (md_en && md_op == 3'd5) begin
                        hi <= rs_data;
                    end else if (md_en && md_op == 3'd6) begin
                        lo <= rs_data;
                    end
                end
                BUSY: begin
                    // Anything arriving from E while busy is dropped; the stall keeps it from happening.
                    if (counter == 4'd1) begin
                        counter <= 4'd0;
                        state   <= IDLE;
                        if (!op_div) begin
                            hi <= product[63:32];
                            lo <= product[31:0];
                        end else if (op_b != 32'd0) begin
                            hi <= rem;
                            lo <= quot;
                        end else if (!DIVZERO_HOLD) begin
                            hi <= op_a;
                            lo <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed test-plan cases plus randomized ops against an arithmetic model.
module tb_md_unit_ctrl;

    logic        clk;
    logic        reset;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int passes;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_unit_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .md_en   (md_en),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic on the architectural rules, no knowledge of the datapath.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        case (op)
            3'd1: begin
                sa = $signed(rs);
                sb = $signed(rt);
                p = sa * sb;
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, rs} * {32'd0, rt};
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd3, 3'd4: begin
                if (rt == 32'd0) begin
`ifndef MD_DIVZERO_HOLD_EN
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = rs;
`endif
                end else if (op == 3'd3) begin
                    sa = $signed(rs);
                    sb = $signed(rt);
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end else begin
                    exp_lo = rs / rt;
                    exp_hi = rs % rt;
                end
            end
            3'd5: exp_hi = rs;
            3'd6: exp_lo = rs;
            default: ;
        endcase
    endtask

    // Issue one op from E, check stall on the issue cycle, busy/stall/old HI-LO through the busy window,
    // then the new HI/LO once busy drops. With noise, junk E-stage traffic is injected while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic dmd, input logic noise);
        int n;
        logic want_stall;
        n = (op == 3'd1 || op == 3'd2) ? 5 : ((op == 3'd3 || op == 3'd4) ? 10 : 0);
        @(negedge clk);
        md_en = 1'b1;
        md_op = op;
        rs_data = rs;
        rt_data = rt;
        d_is_md = dmd;
        #1;
        want_stall = dmd && (n > 0);
        checks++;
        if (stall !== want_stall) $display("[TB] FAIL stall_issue op=%0d got %b want %b", op, stall, want_stall);
        else passes++;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (noise) begin
                md_en = 1'($urandom);
                md_op = 3'($urandom);
                rs_data = $urandom;
                rt_data = $urandom;
            end else begin
                md_en = 1'b0;
                md_op = 3'd0;
            end
            #1;
            checks++;
            if (busy !== 1'b1) $display("[TB] FAIL busy_window op=%0d cyc=%0d got %b want 1", op, k + 1, busy);
            else passes++;
            checks++;
            if (stall !== dmd) $display("[TB] FAIL stall_window op=%0d cyc=%0d got %b want %b", op, k + 1, stall, dmd);
            else passes++;
            checks++;
            if (hi !== exp_hi || lo !== exp_lo)
                $display("[TB] FAIL hold_window op=%0d cyc=%0d got %h_%h want %h_%h", op, k + 1, hi, lo, exp_hi, exp_lo);
            else passes++;
            @(negedge clk);
        end
        md_en = 1'b0;
        md_op = 3'd0;
        #1;
        model_apply(op, rs, rt);
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL busy_done op=%0d got %b want 0", op, busy);
        else passes++;
        checks++;
        if (stall !== 1'b0) $display("[TB] FAIL stall_done op=%0d got %b want 0", op, stall);
        else passes++;
        checks++;
        if (hi !== exp_hi || lo !== exp_lo)
            $display("[TB] FAIL result op=%0d rs=%h rt=%h got %h_%h want %h_%h", op, rs, rt, hi, lo, exp_hi, exp_lo);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        md_en = 1'b0;
        md_op = 3'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        d_is_md = 1'b1;
        repeat (3) @(negedge clk);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL reset_flags got busy=%b stall=%b want 0 0", busy, stall);
        else passes++;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) $display("[TB] FAIL reset_hilo got %h_%h want 0_0", hi, lo);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_mult_div();
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) $display("[TB] FAIL mult_plan got %h_%h want ffffffff_fffffffa", hi, lo);
        else passes++;
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) $display("[TB] FAIL multu_plan got %h_%h want 00000002_fffffffa", hi, lo);
        else passes++;
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) $display("[TB] FAIL div_plan got %h_%h want ffffffff_fffffffd", hi, lo);
        else passes++;
        run_op(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'd1 || lo !== 32'd3) $display("[TB] FAIL divu_plan got %h_%h want 00000001_00000003", hi, lo);
        else passes++;
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) $display("[TB] FAIL div_overflow got %h_%h want 00000000_80000000", hi, lo);
        else passes++;
    endtask

    task automatic test_move();
        run_op(3'd5, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        run_op(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0);
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) $display("[TB] FAIL move_plan got %h_%h want 12345678_9abcdef0", hi, lo);
        else passes++;
        // mthi arriving mid-multiply must be dropped; hi ends at the product's upper half.
        @(negedge clk);
        md_en = 1'b1;
        md_op = 3'd2;
        rs_data = 32'h0001_0000;
        rt_data = 32'h0003_0000;
        @(negedge clk);
        md_op = 3'd5;
        rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        md_en = 1'b0;
        md_op = 3'd0;
        repeat (4) @(negedge clk);
        #1;
        model_apply(3'd2, 32'h0001_0000, 32'h0003_0000);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd3 || lo !== 32'd0) $display("[TB] FAIL mthi_while_busy got busy=%b %h_%h want 0 00000003_00000000", busy, hi, lo);
        else passes++;
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        md_en = 1'b1;
        md_op = 3'd3;
        rs_data = 32'd100;
        rt_data = 32'd7;
        d_is_md = 1'b0;
        @(negedge clk);
        md_en = 1'b0;
        md_op = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) $display("[TB] FAIL reset_busy got busy=%b %h_%h want 0 0_0", busy, hi, lo);
        else passes++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) $display("[TB] FAIL no_late_write cyc=%0d got busy=%b %h_%h", k, busy, hi, lo);
            else passes++;
        end
    endtask

    task automatic test_divzero();
        run_op(3'd5, 32'h0000_AAAA, 32'd0, 1'b0, 1'b0);
        run_op(3'd6, 32'h0000_BBBB, 32'd0, 1'b0, 1'b0);
        run_op(3'd3, 32'd5, 32'd0, 1'b1, 1'b0);
`ifdef MD_DIVZERO_HOLD_EN
        checks++;
        if (hi !== 32'h0000_AAAA || lo !== 32'h0000_BBBB) $display("[TB] FAIL divzero_hold got %h_%h want 0000aaaa_0000bbbb", hi, lo);
        else passes++;
`else
        checks++;
        if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) $display("[TB] FAIL divzero got %h_%h want 00000005_ffffffff", hi, lo);
        else passes++;
`endif
        run_op(3'd4, 32'hF000_0001, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 6));
            run_op(op, pick_operand(), pick_operand(), 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_mult_div();
        test_move();
        test_reset_busy();
        test_divzero();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
